// File: rtl/conv_result_writer.sv
// Sink for the 3x3 convolution result stream: drops edge/unfilled windows and writes the
// surviving results to a linear frame buffer. Optional tags: CONV_RESULT_WRITER_EOL_EN.
module conv_result_writer #(
  parameter int IMG_W      = 502,
  parameter int IMG_H      = 502,
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 18,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data,
`ifdef CONV_RESULT_WRITER_EOL_EN
  output logic              out_eol,
  output logic              out_eof,
`endif
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
`ifdef CONV_RESULT_WRITER_EOL_EN
  localparam int EW = ADDR_W + DATA_W + 2;
`else
  localparam int EW = ADDR_W + DATA_W;
`endif
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [RW-1:0] ROW_MIN  = RW'(2);
  localparam logic [CW-1:0] COL_MIN  = CW'(2);
  localparam logic [PW:0]   CNT_FULL = (PW+1)'(FIFO_DEPTH);
  localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t            state_q;
  logic [CW-1:0]     col_q;
  logic [RW-1:0]     row_q;
  logic [ADDR_W-1:0] addr_q;
  logic              err_q;

  logic [EW-1:0]     mem_q [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr_q;
  logic [PW-1:0]     rd_ptr_q;
  logic [PW:0]       count_q;

  logic              accept;
  logic              push;
  logic              pop;
  logic              col_last;
  logic              row_last;
  logic              start_ok;
  logic [EW-1:0]     entry_d;
  logic [EW-1:0]     head;

  assign col_last  = (col_q == COL_LAST);
  assign row_last  = (row_q == ROW_LAST);
  assign in_ready  = (state_q == S_RUN) && (count_q != CNT_FULL);
  assign accept    = in_valid && in_ready;
  assign push      = accept && (row_q >= ROW_MIN) && (col_q >= COL_MIN);
  assign out_valid = (count_q != '0);
  assign pop       = out_valid && out_ready;
  assign start_ok  = start && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign busy      = (state_q == S_RUN) || (state_q == S_DRAIN);
  // No pushes happen in DRAIN, so popping the only remaining entry there is the final write.
  assign done      = (state_q == S_DRAIN) && pop && (count_q == CNT_ONE);
  assign err       = err_q;
  assign head      = mem_q[rd_ptr_q];

`ifdef CONV_RESULT_WRITER_EOL_EN
  assign entry_d = {addr_q, in_data, col_last, row_last && col_last};
  assign {out_addr, out_data, out_eol, out_eof} = head;
`else
  assign entry_d = {addr_q, in_data};
  assign {out_addr, out_data} = head;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= entry_d;
        wr_ptr_q        <= wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      if (push && !pop) begin
        count_q <= count_q + CNT_ONE;
      end else if (!push && pop) begin
        count_q <= count_q - CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      col_q   <= '0;
      row_q   <= '0;
      addr_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      if (in_valid && !in_ready) begin
        err_q <= 1'b1;
      end else if (start_ok) begin
        err_q <= 1'b0;
      end
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_q <= S_RUN;
            col_q   <= '0;
            row_q   <= '0;
            addr_q  <= '0;
          end
        end
        S_RUN: begin
          if (accept) begin
            if (col_last) begin
              col_q <= '0;
              row_q <= row_last ? '0 : row_q + RW'(1);
            end else begin
              col_q <= col_q + CW'(1);
            end
            if (push) begin
              addr_q <= addr_q + ADDR_W'(1);
            end
            if (row_last && col_last) begin
              state_q <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if ((count_q == '0) || done) begin
            state_q <= S_DONE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_result_writer.sv
// Scoreboard bench for conv_result_writer on a 5x4 image; expected writes are queued as beats are driven.
module tb_conv_result_writer;
  localparam int W  = 5;
  localparam int H  = 4;
  localparam int DW = 8;
  localparam int AW = 5;
  localparam int FD = 4;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          eol;
    logic          eof;
  } exp_t;

  logic clk = 1'b0;
  logic rst, start, in_valid, in_ready, out_valid, out_ready, busy, done, err;
  logic [DW-1:0] in_data, out_data;
  logic [AW-1:0] out_addr;
`ifdef CONV_RESULT_WRITER_EOL_EN
  logic out_eol, out_eof;
`endif

  exp_t sb[$];
  exp_t mon_e;
  int chk_cnt  = 0;
  int pass_cnt = 0;
  int writes   = 0;
  int m_row, m_col, m_addr;

  conv_result_writer #(
    .IMG_W(W), .IMG_H(H), .DATA_W(DW), .ADDR_W(AW), .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
    .out_addr(out_addr), .out_data(out_data),
`ifdef CONV_RESULT_WRITER_EOL_EN
    .out_eol(out_eol), .out_eof(out_eof),
`endif
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Write monitor: each handshake pops the scoreboard and checks the done pulse alongside it.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) begin
        writes++;
        chk_cnt++;
        if (sb.size() == 0) begin
          $display("FAIL unexpected_write: got addr=%0d data=%0d, required no write", out_addr, out_data);
        end else begin
          mon_e = sb.pop_front();
          if (out_addr !== mon_e.addr || out_data !== mon_e.data)
            $display("FAIL write: got addr=%0d data=%0d, required addr=%0d data=%0d",
                     out_addr, out_data, mon_e.addr, mon_e.data);
          else pass_cnt++;
          chk_cnt++;
          if (done !== mon_e.eof)
            $display("FAIL done_on_write: addr=%0d done=%b, required %b", out_addr, done, mon_e.eof);
          else pass_cnt++;
`ifdef CONV_RESULT_WRITER_EOL_EN
          chk_cnt++;
          if (out_eol !== mon_e.eol || out_eof !== mon_e.eof)
            $display("FAIL eol_eof: addr=%0d got eol=%b eof=%b, required eol=%b eof=%b",
                     out_addr, out_eol, out_eof, mon_e.eol, mon_e.eof);
          else pass_cnt++;
`endif
        end
      end else begin
        chk_cnt++;
        if (done !== 1'b0) $display("FAIL done_idle: done=%b without handshake, required 0", done);
        else pass_cnt++;
      end
    end
  end

  task automatic do_start();
    start  = 1'b1;
    m_row  = 0;
    m_col  = 0;
    m_addr = 0;
    writes = 0;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_beat(input int k);
    int   guard;
    exp_t e;
    guard = 0;
    while (in_ready !== 1'b1 && guard < 500) begin
      @(posedge clk); #1;
      guard++;
    end
    if (in_ready !== 1'b1) begin
      chk_cnt++;
      $display("FAIL beat_ready_timeout: beat=%0d in_ready=%b, required 1", k, in_ready);
      return;
    end
    in_valid = 1'b1;
    in_data  = DW'(k);
    if (m_row >= 2 && m_col >= 2) begin
      e.addr = AW'(m_addr);
      e.data = DW'(k);
      e.eol  = (m_col == W - 1);
      e.eof  = (m_col == W - 1) && (m_row == H - 1);
      sb.push_back(e);
      m_addr++;
    end
    if (m_col == W - 1) begin
      m_col = 0;
      m_row = m_row + 1;
    end else begin
      m_col = m_col + 1;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int guard;
    guard = 0;
    while (sb.size() != 0 && guard < 300) begin
      @(posedge clk); #1;
      guard++;
    end
    chk_cnt++;
    if (sb.size() != 0) $display("FAIL %s_drain_timeout: %0d writes outstanding, required 0", tag, sb.size());
    else pass_cnt++;
    chk_cnt++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || done !== 1'b0)
      $display("FAIL %s_end_state: busy=%b out_valid=%b done=%b, required 0 0 0", tag, busy, out_valid, done);
    else pass_cnt++;
    chk_cnt++;
    if (writes != 6) $display("FAIL %s_write_count: got %0d, required 6", tag, writes);
    else pass_cnt++;
    $display("%s: frame complete, %0d writes", tag, writes);
  endtask

  task automatic check_zero_outputs(input string tag);
    chk_cnt++;
    if ({in_ready, out_valid, out_addr, out_data, busy, done, err} !== '0)
      $display("FAIL %s: in_ready=%b out_valid=%b addr=%0d data=%0d busy=%b done=%b err=%b, required all 0",
               tag, in_ready, out_valid, out_addr, out_data, busy, done, err);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_zero_outputs("reset_held");
    rst = 1'b0;
    @(posedge clk); #1;
    check_zero_outputs("reset_released");
    $display("test_reset: done");
  endtask

  task automatic test_full_frame();
    out_ready = 1'b1;
    do_start();
    chk_cnt++;
    if (busy !== 1'b1 || in_ready !== 1'b1) $display("FAIL run_entry: busy=%b in_ready=%b, required 1 1", busy, in_ready);
    else pass_cnt++;
    for (int k = 0; k < 12; k++) send_beat(k);
    chk_cnt++;
    if (out_valid !== 1'b0) $display("FAIL no_early_write: out_valid=%b, required 0", out_valid);
    else pass_cnt++;
    send_beat(12);
    chk_cnt++;
    if (out_valid !== 1'b1 || out_addr !== 5'd0 || out_data !== 8'd12)
      $display("FAIL latency: out_valid=%b addr=%0d data=%0d, required 1 0 12", out_valid, out_addr, out_data);
    else pass_cnt++;
    for (int k = 13; k < 20; k++) send_beat(k);
    wait_done("full_frame");
    chk_cnt++;
    if (err !== 1'b0) $display("FAIL full_frame_err: err=%b, required 0", err);
    else pass_cnt++;
  endtask

  task automatic stall_frame(input bit inject_err);
    out_ready = 1'b1;
    do_start();
    for (int k = 0; k < 12; k++) send_beat(k);
    out_ready = 1'b0;
    for (int k = 12; k < 18; k++) send_beat(k);
    chk_cnt++;
    if (in_ready !== 1'b0 || out_addr !== 5'd0 || out_data !== 8'd12)
      $display("FAIL stall_full: in_ready=%b addr=%0d data=%0d, required 0 0 12", in_ready, out_addr, out_data);
    else pass_cnt++;
    if (inject_err) begin
      in_valid = 1'b1;
      in_data  = 8'd99;
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk_cnt++;
      if (err !== 1'b1) $display("FAIL err_set: err=%b, required 1", err);
      else pass_cnt++;
    end
    repeat (3) @(posedge clk);
    #1;
    chk_cnt++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_addr !== 5'd0 || out_data !== 8'd12 || err !== inject_err)
      $display("FAIL stall_hold: in_ready=%b out_valid=%b addr=%0d data=%0d err=%b, required 0 1 0 12 %b",
               in_ready, out_valid, out_addr, out_data, err, inject_err);
    else pass_cnt++;
    out_ready = 1'b1;
    send_beat(18);
    send_beat(19);
  endtask

  task automatic test_backpressure();
    stall_frame(1'b0);
    wait_done("backpressure");
    chk_cnt++;
    if (err !== 1'b0) $display("FAIL backpressure_err: err=%b, required 0", err);
    else pass_cnt++;
  endtask

  task automatic test_protocol_error();
    stall_frame(1'b1);
    wait_done("protocol_error");
    chk_cnt++;
    if (err !== 1'b1) $display("FAIL err_sticky: err=%b, required 1", err);
    else pass_cnt++;
    do_start();
    chk_cnt++;
    if (err !== 1'b0 || busy !== 1'b1) $display("FAIL err_clear_on_start: err=%b busy=%b, required 0 1", err, busy);
    else pass_cnt++;
    for (int k = 0; k < 20; k++) send_beat(k);
    wait_done("after_error");
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    do_start();
    for (int k = 0; k < 16; k++) send_beat(k);
    rst = 1'b1;
    @(posedge clk); #1;
    check_zero_outputs("reset_mid");
    rst = 1'b0;
    sb.delete();
    @(posedge clk); #1;
    chk_cnt++;
    if (busy !== 1'b0 || in_ready !== 1'b0) $display("FAIL reset_mid_idle: busy=%b in_ready=%b, required 0 0", busy, in_ready);
    else pass_cnt++;
    do_start();
    for (int k = 0; k < 20; k++) send_beat(k);
    wait_done("reset_mid_restart");
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    do_start();
    for (int k = 0; k < 13; k++) send_beat(k);
    start = 1'b1;
    send_beat(13);
    start = 1'b0;
    chk_cnt++;
    if (busy !== 1'b1) $display("FAIL start_while_busy: busy=%b, required 1", busy);
    else pass_cnt++;
    for (int k = 14; k < 20; k++) send_beat(k);
    wait_done("busy_start");
    do_start();
    chk_cnt++;
    if (busy !== 1'b1) $display("FAIL restart_from_done: busy=%b, required 1", busy);
    else pass_cnt++;
    for (int k = 0; k < 20; k++) send_beat(k);
    wait_done("restart");
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    test_reset();
    test_full_frame();
    test_backpressure();
    test_protocol_error();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete, required completion");
    $fatal(1, "timeout");
  end

endmodule
